// File: rtl/sweep_cmd_decoder.sv
// rtl/sweep_cmd_decoder.sv - pops 11-byte command frames, validates them and drives sweep/PLL config
module sweep_cmd_decoder #(
  parameter int          FRAME_BYTES = 11,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [31:0] DEF_DWELL   = 32'd1000,
  parameter int          CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*FRAME_BYTES-1:0] fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic                     sweep_busy,
  output logic [31:0]              start_word,
  output logic [31:0]              step_word,
  output logic [31:0]              dwell_cycles,
  output logic [15:0]              kp,
  output logic [15:0]              ki,
  output logic                     sweep_start,
  output logic                     sweep_stop,
  output logic                     cfg_valid,
  output logic [CNT_W-1:0]         frame_ok_cnt,
  output logic [CNT_W-1:0]         frame_err_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_t;

  state_t                   state;
  logic [8*FRAME_BYTES-1:0] frame_q;
  logic                     ok_q;

  logic [7:0]  hdr;
  logic [7:0]  cmd;
  logic [7:0]  csum_rx;
  logic [7:0]  csum_calc;
  logic [31:0] field_a;
  logic [31:0] field_b;
  logic        cmd_legal;

  assign hdr     = frame_q[7:0];
  assign cmd     = frame_q[15:8];
  assign field_a = {frame_q[23:16], frame_q[31:24], frame_q[39:32], frame_q[47:40]};
  assign field_b = {frame_q[55:48], frame_q[63:56], frame_q[71:64], frame_q[79:72]};
  assign csum_rx = frame_q[87:80];

  always_comb begin
    csum_calc = 8'h00;
    for (int k = 0; k < 10; k++) begin
      csum_calc = csum_calc ^ frame_q[8*k +: 8];
    end
  end

  // Configuration writes are refused mid-sweep so the sweeper never sees a half-updated setup.
  always_comb begin
    cmd_legal = 1'b0;
    case (cmd)
      8'h01:   cmd_legal = !sweep_busy;
      8'h02:   cmd_legal = !sweep_busy && (field_a != 32'd0);
      8'h03:   cmd_legal = cfg_valid && !sweep_busy;
      8'h04:   cmd_legal = 1'b1;
      8'h05:   cmd_legal = !sweep_busy;
      default: cmd_legal = 1'b0;
    endcase
  end

  assign fifo_rd_en = (state == IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      frame_q       <= '0;
      ok_q          <= 1'b0;
      start_word    <= '0;
      step_word     <= '0;
      dwell_cycles  <= DEF_DWELL;
      kp            <= '0;
      ki            <= '0;
      sweep_start   <= 1'b0;
      sweep_stop    <= 1'b0;
      cfg_valid     <= 1'b0;
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      sweep_start <= 1'b0;
      sweep_stop  <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            frame_q <= fifo_dout;
            state   <= CHECK;
          end
        end
        CHECK: begin
          ok_q  <= (hdr == HEADER) && (csum_calc == csum_rx) && cmd_legal;
          state <= APPLY;
        end
        APPLY: begin
          if (ok_q) begin
            case (cmd)
              8'h01: begin
                start_word <= field_a;
                step_word  <= field_b;
                cfg_valid  <= 1'b1;
              end
              8'h02:   dwell_cycles <= field_a;
              8'h03:   sweep_start  <= 1'b1;
              8'h04:   sweep_stop   <= 1'b1;
              8'h05: begin
                kp <= field_a[15:0];
                ki <= field_b[15:0];
              end
              default: ;
            endcase
            if (frame_ok_cnt != {CNT_W{1'b1}}) frame_ok_cnt <= frame_ok_cnt + 1'b1;
          end else begin
            if (frame_err_cnt != {CNT_W{1'b1}}) frame_err_cnt <= frame_err_cnt + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_cmd_decoder.sv
// tb/tb_sweep_cmd_decoder.sv - directed vector bench for sweep_cmd_decoder
module tb_sweep_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [87:0] fifo_dout;
  logic        fifo_empty;
  logic        sweep_busy;

  logic        fifo_rd_en;
  logic [31:0] start_word, step_word, dwell_cycles;
  logic [15:0] kp, ki;
  logic        sweep_start, sweep_stop, cfg_valid;
  logic [15:0] frame_ok_cnt, frame_err_cnt;

  logic        s_rd_en;
  logic [31:0] s_start_word, s_step_word, s_dwell;
  logic [15:0] s_kp, s_ki;
  logic        s_start, s_stop, s_cfg;
  logic [3:0]  s_ok_cnt, s_err_cnt;

  always #5 clk = ~clk;

  sweep_cmd_decoder dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .sweep_busy(sweep_busy), .start_word(start_word),
    .step_word(step_word), .dwell_cycles(dwell_cycles), .kp(kp), .ki(ki),
    .sweep_start(sweep_start), .sweep_stop(sweep_stop), .cfg_valid(cfg_valid),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
  );

  // Narrow-counter instance shares all inputs so saturation is reached in a few frames.
  sweep_cmd_decoder #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(s_rd_en), .sweep_busy(sweep_busy), .start_word(s_start_word),
    .step_word(s_step_word), .dwell_cycles(s_dwell), .kp(s_kp), .ki(s_ki),
    .sweep_start(s_start), .sweep_stop(s_stop), .cfg_valid(s_cfg),
    .frame_ok_cnt(s_ok_cnt), .frame_err_cnt(s_err_cnt)
  );

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        flip;
    logic        busy;
    logic        ok;
    logic        start;
    logic        stop;
    logic        cfg;
    logic [31:0] sw;
    logic [31:0] stw;
    logic [31:0] dw;
    logic [15:0] kp;
    logic [15:0] ki;
  } vec_t;

  vec_t v[14];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_ok = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [87:0] mk(input logic [7:0] hdr, input logic [7:0] cmd,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic flip);
    logic [7:0]  by [11];
    logic [87:0] f;
    by[0] = hdr; by[1] = cmd;
    by[2] = a[31:24]; by[3] = a[23:16]; by[4] = a[15:8]; by[5] = a[7:0];
    by[6] = b[31:24]; by[7] = b[23:16]; by[8] = b[15:8]; by[9] = b[7:0];
    by[10] = 8'h00;
    for (int k = 0; k < 10; k++) by[10] = by[10] ^ by[k];
    if (flip) by[10] = ~by[10];
    f = '0;
    for (int k = 0; k < 11; k++) f[8*k +: 8] = by[k];
    return f;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // Holds fifo_empty low for n back-to-back frames; rd_en must pulse every third clock.
  task automatic hold_pops(input int n, input logic [87:0] f);
    for (int i = 0; i < 3 * n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        fifo_dout  = f;
        fifo_empty = 1'b0;
      end
      #1;
      chk("pop_spacing", {31'd0, fifo_rd_en}, {31'd0, (i % 3) == 0});
    end
    @(negedge clk);
    fifo_empty = 1'b1;
  endtask

  initial begin
    v[0]  = '{8'hA5, 8'h03, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd1000, 16'h0, 16'h0};
    v[1]  = '{8'hA5, 8'h01, 32'h01000000, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd1000, 16'h0, 16'h0};
    v[2]  = '{8'hA5, 8'h03, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd1000, 16'h0, 16'h0};
    v[3]  = '{8'hA5, 8'h01, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd1000, 16'h0, 16'h0};
    v[4]  = '{8'h5A, 8'h05, 32'h00001111, 32'h00002222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd1000, 16'h0, 16'h0};
    v[5]  = '{8'hA5, 8'h02, 32'd500, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd1000, 16'h0, 16'h0};
    v[6]  = '{8'hA5, 8'h02, 32'd500, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h0, 16'h0};
    v[7]  = '{8'hA5, 8'h04, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h0, 16'h0};
    v[8]  = '{8'hA5, 8'h05, 32'h00001234, 32'hABCD5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h1234, 16'h5678};
    v[9]  = '{8'hA5, 8'h02, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h1234, 16'h5678};
    v[10] = '{8'hA5, 8'h06, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h1234, 16'h5678};
    v[11] = '{8'hA5, 8'h03, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h1234, 16'h5678};
    v[12] = '{8'hA5, 8'h05, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h1234, 16'h5678};
    v[13] = '{8'hA5, 8'h01, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01000000, 32'h00000100, 32'd500, 16'h1234, 16'h5678};

    reset      = 1'b1;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    sweep_busy = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dwell", dwell_cycles, 32'd1000);
    chk("rst_start_word", start_word, 32'd0);
    chk("rst_step_word", step_word, 32'd0);
    chk("rst_gains", {kp, ki}, 32'd0);
    chk("rst_flags", {29'd0, sweep_start, sweep_stop, cfg_valid}, 32'd0);
    chk("rst_counters", {frame_ok_cnt, frame_err_cnt}, 32'd0);
    chk("idle_rd_en_empty", {31'd0, fifo_rd_en}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      fifo_dout  = mk(v[i].hdr, v[i].cmd, v[i].a, v[i].b, v[i].flip);
      sweep_busy = v[i].busy;
      fifo_empty = 1'b0;
      @(negedge clk);
      fifo_empty = 1'b1;
      @(negedge clk);
      chk("pre_apply_ok_cnt", {16'd0, frame_ok_cnt}, exp_ok);
      chk("pre_apply_err_cnt", {16'd0, frame_err_cnt}, exp_err);
      @(negedge clk);
      if (v[i].ok) exp_ok++;
      else exp_err++;
      chk("start_word", start_word, v[i].sw);
      chk("step_word", step_word, v[i].stw);
      chk("dwell_cycles", dwell_cycles, v[i].dw);
      chk("kp", {16'd0, kp}, {16'd0, v[i].kp});
      chk("ki", {16'd0, ki}, {16'd0, v[i].ki});
      chk("cfg_valid", {31'd0, cfg_valid}, {31'd0, v[i].cfg});
      chk("sweep_start", {31'd0, sweep_start}, {31'd0, v[i].start});
      chk("sweep_stop", {31'd0, sweep_stop}, {31'd0, v[i].stop});
      chk("frame_ok_cnt", {16'd0, frame_ok_cnt}, exp_ok);
      chk("frame_err_cnt", {16'd0, frame_err_cnt}, exp_err);
      @(negedge clk);
      chk("start_pulse_end", {31'd0, sweep_start}, 32'd0);
      chk("stop_pulse_end", {31'd0, sweep_stop}, 32'd0);
    end
    sweep_busy = 1'b0;

    hold_pops(3, mk(8'h5A, 8'h04, 32'h0, 32'h0, 1'b0));
    exp_err += 3;
    chk("spacing_err_cnt", {16'd0, frame_err_cnt}, exp_err);
    chk("spacing_ok_cnt", {16'd0, frame_ok_cnt}, exp_ok);

    hold_pops(20, mk(8'hA5, 8'h01, 32'h0, 32'h0, 1'b1));
    exp_err += 20;
    chk("main_err_cnt", {16'd0, frame_err_cnt}, exp_err);
    chk("sat_err_cnt", {28'd0, s_err_cnt}, sat15(exp_err));
    chk("sat_ok_cnt", {28'd0, s_ok_cnt}, sat15(exp_ok));
    chk("sat_regs_held", s_start_word, 32'h01000000);

    @(negedge clk);
    fifo_dout  = mk(8'hA5, 8'h04, 32'h0, 32'h0, 1'b0);
    fifo_empty = 1'b0;
    @(negedge clk);
    fifo_empty = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_no_stop", {31'd0, sweep_stop}, 32'd0);
      chk("rst_mid_counters", {frame_ok_cnt, frame_err_cnt}, 32'd0);
      chk("rst_mid_sat_counters", {24'd0, s_ok_cnt, s_err_cnt}, 32'd0);
    end
    chk("rst_mid_dwell", dwell_cycles, 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
